// File: rtl/ex_muldiv_seq.sv
// RV32M multi-cycle multiply/divide sequencer sitting beside EX.
// Shift-add multiply and restoring divide, one bit per cycle, sign fix-up at the end.
module ex_muldiv_seq #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            flush,
  output logic            busy,
  output logic            stall_ex,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       cnt;
  logic [2:0]          op_q;
  logic                sa_q, sb_q;
  logic [XLEN-1:0]     opnd_q;
  logic [2*XLEN-1:0]   acc_q;

  logic                a_sgn, b_sgn, sa_in, sb_in;
  logic [XLEN-1:0]     abs_a, abs_b;
  logic                div_zero, ovf, special, accept;
  logic [XLEN-1:0]     special_res;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_nx, div_nx, prod_s;
  logic [2*XLEN:0]     div_sh;
  logic [XLEN:0]       div_r, div_sub;
  logic [XLEN-1:0]     quo_s, rem_s, fix_res;

  // Operand decode at start time
  always_comb begin
    a_sgn    = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    b_sgn    = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    sa_in    = a_sgn & src_a[XLEN-1];
    sb_in    = b_sgn & src_b[XLEN-1];
    abs_a    = sa_in ? -src_a : src_a;
    abs_b    = sb_in ? -src_b : src_b;
    div_zero = op[2] && (src_b == '0);
    ovf      = op[2] && !op[0] && (src_a == MIN_NEG) && (src_b == '1);
    special  = div_zero || ovf;
    accept   = start && (state == S_IDLE) && !flush;
    if (div_zero) special_res = op[1] ? src_a : '1;
    else          special_res = op[1] ? '0 : MIN_NEG;
  end

  // One iteration of each algorithm
  always_comb begin
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_nx  = {mul_sum, acc_q[XLEN-1:1]};
    div_sh  = {acc_q, 1'b0};
    div_r   = div_sh[2*XLEN:XLEN];
    div_sub = div_r - {1'b0, opnd_q};
    if (div_r >= {1'b0, opnd_q}) div_nx = {div_sub[XLEN-1:0], div_sh[XLEN-1:1], 1'b1};
    else                         div_nx = {div_r[XLEN-1:0], div_sh[XLEN-1:0]};
  end

  always_comb begin
    prod_s = (sa_q ^ sb_q) ? -acc_q : acc_q;
    quo_s  = (sa_q ^ sb_q) ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    rem_s  = sa_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    case (op_q)
      3'b000:          fix_res = prod_s[XLEN-1:0];
      3'b100, 3'b101:  fix_res = quo_s;
      3'b110, 3'b111:  fix_res = rem_s;
      default:         fix_res = prod_s[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (accept) state_nx = special ? S_DONE : S_CALC;
      S_CALC:  if (cnt == CW'(XLEN - 1)) state_nx = S_FIXUP;
      S_FIXUP: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      op_q   <= '0;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      opnd_q <= '0;
      acc_q  <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: if (accept) begin
          op_q   <= op;
          sa_q   <= sa_in;
          sb_q   <= sb_in;
          cnt    <= '0;
          // Multiplier / dividend sits in the low half; the other operand is held aside
          acc_q  <= op[2] ? {{XLEN{1'b0}}, abs_a} : {{XLEN{1'b0}}, abs_b};
          opnd_q <= op[2] ? abs_b : abs_a;
          if (special) result <= special_res;
        end
        S_CALC: if (!flush) begin
          cnt   <= cnt + 1'b1;
          acc_q <= op_q[2] ? div_nx : mul_nx;
        end
        S_FIXUP: if (!flush) result <= fix_res;
        default: ;
      endcase
    end
  end

  assign busy     = (state != S_IDLE);
  assign stall_ex = (start && (state == S_IDLE)) || (state == S_CALC) || (state == S_FIXUP);
  assign done     = (state == S_DONE) && !flush;

endmodule
